pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and stall controller for the in-order pipelined CPU.
- Replaces ad-hoc hazard handling with a shadow pipeline of destination tags: STAGES entries, where stage 1 = EX and stage STAGES = WB.
- Decides per cycle whether the ID instruction may issue and where each source operand comes from.
- Supplies the WB register-write tag to the register file.

Parameters:
STAGES, 3, number of post-ID stages tracked (1=EX … STAGES=WB), ≥2
REG_ADDR_W, 5, register index width
LOAD_STAGE, 2, first stage whose output register holds load data (1 < LOAD_STAGE ≤ STAGES)
FWD_EN, 1, 1 = forwarding mode, 0 = stall-only mode
RF_BYPASS, 1, 1 = register file returns the same-cycle WB write on read
CNT_W, 16, stall counter width
(derived) SEL_W = $clog2(STAGES+1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a valid instruction
id_rs1 / id_rs2  in  REG_ADDR_W  source registers
id_rs1_used / id_rs2_used  in  1  source is actually read
id_rd  in  REG_ADDR_W  destination register
id_reg_write  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
pipe_hold  in  1  freeze entire shadow pipeline (multi-cycle memory)
flush  in  1  branch taken in EX; kill the ID instruction
id_ready  out  1  ID instruction may issue this cycle
issue  out  1  id_valid & id_ready & !flush & !pipe_hold
fwd_sel_rs1 / fwd_sel_rs2  out  SEL_W  0 = regfile, k = stage k output
wb_reg_write  out  1  stage STAGES valid & reg_write
wb_rd  out  REG_ADDR_W  stage STAGES rd
stall_cnt  out  CNT_W  cycles lost to hazard stalls

Behaviour:
- Clocking and reset: one clock domain (clk). reset is asynchronous, active-high.
- Reset values: all stage entries are invalid. stall_cnt=0, wb_reg_write=0, wb_rd=0. fwd_sel is 0 by construction.
- Entry fields: valid, reg_write, rd, is_load.
- Matching: stage k matches source s when valid & reg_write & rd==s & s!=0 & s_used.
  - Register 0 never hazards.
  - Unused sources never hazard.
  - The youngest match (lowest k) wins.
- Forwarding mode (FWD_EN=1), per source:
  - Youngest match k at a load with k<LOAD_STAGE → hazard stall.
  - Youngest match k with k<STAGES, or k=STAGES with RF_BYPASS=0 → fwd_sel=k.
  - Youngest match k=STAGES with RF_BYPASS=1 → fwd_sel=0.
  - No match → fwd_sel=0.
- Stall-only mode (FWD_EN=0): any match in stages 1..STAGES-1 (or 1..STAGES if RF_BYPASS=0) → hazard stall. fwd_sel is always 0.
- id_ready = !hazard & !pipe_hold. Combinational from the ID inputs and the stage state, zero latency.
- Shift, when pipe_hold=0:
  - Stage 1 ← ID fields if issue, else a bubble (valid=0).
  - Stage k ← stage k-1 for k=2..STAGES.
- Hold: when pipe_hold=1 all entries keep their values; issue=0; flush has no effect that cycle. The source keeps flush asserted until a non-held cycle.
- Flush: forces issue=0, so a bubble enters stage 1. Older entries shift normally (the branch itself continues).
- Simultaneous flush and hazard: flush wins; the bubble enters; the stall is not counted.
- stall_cnt: +1 each cycle with id_valid & hazard & !pipe_hold & !flush. Saturates at all-ones, never wraps.
- wb_reg_write / wb_rd: combinational from stage STAGES.
- Mid-operation reset clears all entries immediately, so no register write occurs in the next cycle.

Decomposition:
- Shared package pipe_pkg:
  - Stage-entry struct {valid, reg_write, rd, is_load}.
  - FWD_REGFILE=0 constant.
  - Default REG_ADDR_W.
- One natural sub-module: hazard_src_match. It is combinational and instantiated twice, once per source. It takes the stage vector and one source, and returns the hazard bit and fwd_sel.
- The shift register and stall counter stay in the top.

Test Plan (defaults unless stated):
- ALU back-to-back: issue add rd=5, next cycle ID rs1=5 → id_ready=1, fwd_sel_rs1=1. One cycle later on a dependent → fwd_sel=2.
- Load-use: issue lw rd=7, next cycle ID rs2=7 → id_ready=0 for 1 cycle, stall_cnt=1. Then issue with fwd_sel_rs2=2.
- Youngest wins / r0: stage1 and stage2 both have rd=3, ID rs1=3 → fwd_sel_rs1=1. ID rs1=0 with a stage-1 entry rd=0 → fwd_sel=0, no stall.
- Stall-only (FWD_EN=0) with add rd=4 then dependent → id_ready=0 for 2 cycles, stall_cnt=2. At WB, wb_rd=4, wb_reg_write=1, then issue with fwd_sel=0.
- Hold and flush: pipe_hold=1 for 3 cycles → entries and wb outputs are frozen, issue=0, no stall_cnt increment. flush with id_valid=1 → issue=0, and stage 1 is a bubble next cycle.
- Reset and saturation: assert reset mid-stream → wb_reg_write=0 asynchronously. With CNT_W=2, 5 hazard cycles → stall_cnt=3.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage-entry layout,
// forwarding constants and default register-index width.
package pipe_pkg;

  localparam int DEFAULT_REG_ADDR_W = 5;
  localparam int FWD_REGFILE        = 0;

  // Stage entry at the default register width; the top rebuilds the same
  // layout locally so that REG_ADDR_W can be overridden.
  typedef struct packed {
    logic                          valid;
    logic                          reg_write;
    logic [DEFAULT_REG_ADDR_W-1:0] rd;
    logic                          is_load;
  } stage_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_match.sv
// Per-source hazard detector: finds the youngest producing stage for one
// source register and derives the stall request and operand-forward select.
module hazard_src_match
  import pipe_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int LOAD_STAGE = 2,
  parameter int FWD_EN     = 1,
  parameter int RF_BYPASS  = 1,
  parameter int SEL_W      = $clog2(STAGES+1)
) (
  input  logic [STAGES-1:0]                 stg_valid,
  input  logic [STAGES-1:0]                 stg_reg_write,
  input  logic [STAGES-1:0]                 stg_is_load,
  input  logic [STAGES-1:0][REG_ADDR_W-1:0] stg_rd,
  input  logic [REG_ADDR_W-1:0]             src,
  input  logic                              src_used,
  output logic                              hazard,
  output logic [SEL_W-1:0]                  fwd_sel
);

  localparam int STALL_LAST = (RF_BYPASS != 0) ? STAGES - 1 : STAGES;

  logic [STAGES-1:0] match;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_match
      assign match[gi] = stg_valid[gi] & stg_reg_write[gi] & (stg_rd[gi] == src)
                         & (src != '0) & src_used;
    end
  endgenerate

  always_comb begin
    hazard  = 1'b0;
    fwd_sel = SEL_W'(FWD_REGFILE);
    if (FWD_EN != 0) begin
      // Walk oldest to youngest so the youngest match has the final say.
      for (int k = STAGES; k >= 1; k--) begin
        if (match[k-1]) begin
          hazard  = stg_is_load[k-1] && (k < LOAD_STAGE);
          fwd_sel = (k == STAGES && RF_BYPASS != 0) ? SEL_W'(FWD_REGFILE) : SEL_W'(k);
        end
      end
    end else begin
      for (int k = 1; k <= STALL_LAST; k++) begin
        if (match[k-1]) hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding/stall controller: a shadow pipeline of destination tags
// (stage 1 = EX .. STAGES = WB) gates ID issue and steers operand bypasses.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int LOAD_STAGE = 2,
  parameter int FWD_EN     = 1,
  parameter int RF_BYPASS  = 1,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = $clog2(STAGES+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  pipe_hold,
  input  logic                  flush,
  output logic                  id_ready,
  output logic                  issue,
  output logic [SEL_W-1:0]      fwd_sel_rs1,
  output logic [SEL_W-1:0]      fwd_sel_rs2,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_load;
  } entry_t;

  entry_t                           stage_reg [1:STAGES];
  logic   [STAGES-1:0]              stg_valid;
  logic   [STAGES-1:0]              stg_reg_write;
  logic   [STAGES-1:0]              stg_is_load;
  logic   [STAGES-1:0][REG_ADDR_W-1:0] stg_rd;
  logic                             hazard_rs1;
  logic                             hazard_rs2;
  logic                             hazard;
  logic   [CNT_W-1:0]               stall_cnt_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_unpack
      assign stg_valid[gi]     = stage_reg[gi+1].valid;
      assign stg_reg_write[gi] = stage_reg[gi+1].reg_write;
      assign stg_is_load[gi]   = stage_reg[gi+1].is_load;
      assign stg_rd[gi]        = stage_reg[gi+1].rd;
    end
  endgenerate

  hazard_src_match #(
    .STAGES(STAGES), .REG_ADDR_W(REG_ADDR_W), .LOAD_STAGE(LOAD_STAGE),
    .FWD_EN(FWD_EN), .RF_BYPASS(RF_BYPASS), .SEL_W(SEL_W)
  ) u_match_rs1 (
    .stg_valid(stg_valid), .stg_reg_write(stg_reg_write), .stg_is_load(stg_is_load),
    .stg_rd(stg_rd), .src(id_rs1), .src_used(id_rs1_used),
    .hazard(hazard_rs1), .fwd_sel(fwd_sel_rs1)
  );

  hazard_src_match #(
    .STAGES(STAGES), .REG_ADDR_W(REG_ADDR_W), .LOAD_STAGE(LOAD_STAGE),
    .FWD_EN(FWD_EN), .RF_BYPASS(RF_BYPASS), .SEL_W(SEL_W)
  ) u_match_rs2 (
    .stg_valid(stg_valid), .stg_reg_write(stg_reg_write), .stg_is_load(stg_is_load),
    .stg_rd(stg_rd), .src(id_rs2), .src_used(id_rs2_used),
    .hazard(hazard_rs2), .fwd_sel(fwd_sel_rs2)
  );

  assign hazard       = hazard_rs1 | hazard_rs2;
  assign id_ready     = ~hazard & ~pipe_hold;
  assign issue        = id_valid & id_ready & ~flush & ~pipe_hold;
  assign wb_reg_write = stage_reg[STAGES].valid & stage_reg[STAGES].reg_write;
  assign wb_rd        = stage_reg[STAGES].rd;
  assign stall_cnt    = stall_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= STAGES; k++) stage_reg[k] <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (!pipe_hold) begin
        // A non-issuing cycle (stall, flush or empty ID) injects a clean bubble.
        stage_reg[1] <= issue ? entry_t'{valid: 1'b1, reg_write: id_reg_write,
                                         rd: id_rd, is_load: id_is_load}
                              : '0;
        for (int k = 2; k <= STAGES; k++) stage_reg[k] <= stage_reg[k-1];
      end
      if (id_valid && hazard && !pipe_hold && !flush && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

endmodule
